// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core types and register-file constants
package core_pkg;

  localparam int CORE_DW   = 32;
  localparam int CORE_NREG = 16;
  localparam int CORE_AW   = $clog2(CORE_NREG);

  typedef logic [CORE_DW-1:0]   word_t;
  typedef logic [CORE_AW-1:0]   reg_addr_t;
  typedef logic [CORE_NREG-1:0] reg_list_t;

  localparam reg_addr_t REG_PC = 4'd15;

  typedef enum logic {
    WB_IDLE = 1'b0,
    WB_LOAD = 1'b1
  } wb_state_e;

endpackage

// File: rtl/core_prio_enc16.sv
// rtl/core_prio_enc16.sv - lowest-set-bit encoder over a 16-bit register list
module core_prio_enc16
  import core_pkg::*;
(
  input  reg_list_t list,
  output reg_addr_t addr,
  output logic      none
);

  // Scan downwards so the lowest set bit is the last assignment to win.
  always_comb begin
    addr = '0;
    for (int i = CORE_NREG - 1; i >= 0; i--) begin
      if (list[i]) addr = reg_addr_t'(i);
    end
  end

  assign none = (list == '0);

endmodule

// File: rtl/core_wb_seq.sv
// rtl/core_wb_seq.sv - GPR writeback sequencer merging ALU results and LDR/LDM load beats
module core_wb_seq
  import core_pkg::*;
#(
  parameter  int DW   = 32,
  parameter  int NREG = 16,
  localparam int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_addr,
  input  logic [DW-1:0]   alu_data,
  input  logic            ld_start,
  output logic            ld_ready,
  input  logic [NREG-1:0] ld_reglist,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  output logic            ld_done,
  output logic            ld_err,
  output logic            wb,
  output logic [AW-1:0]   wb_addr,
  output logic [DW-1:0]   wb_data,
  output logic            pc_wr
);

  wb_state_e state;
  reg_list_t list;
  reg_list_t list_rest;
  reg_addr_t beat_addr;
  logic      list_empty;

  core_prio_enc16 u_enc (
    .list (list),
    .addr (beat_addr),
    .none (list_empty)
  );

  assign list_rest = list & ~(reg_list_t'(1) << beat_addr);
  assign ld_ready  = (state == WB_IDLE);
  // Memory beats own the write port whenever a load is in flight.
  assign alu_ready = !(state == WB_LOAD && mem_rvalid);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= WB_IDLE;
      list    <= '0;
      wb      <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
      pc_wr   <= 1'b0;
      ld_done <= 1'b0;
      ld_err  <= 1'b0;
    end else begin
      wb      <= 1'b0;
      pc_wr   <= 1'b0;
      ld_done <= 1'b0;
      ld_err  <= 1'b0;
      case (state)
        WB_IDLE: begin
          // A beat in IDLE (including the ld_start cycle) is stray and dropped.
          ld_err <= mem_rvalid;
          if (ld_start) begin
            if (ld_reglist != '0) begin
              list  <= ld_reglist;
              state <= WB_LOAD;
            end else begin
              ld_done <= 1'b1;
            end
          end
          if (alu_valid) begin
            wb      <= 1'b1;
            wb_addr <= alu_addr;
            wb_data <= alu_data;
            pc_wr   <= (alu_addr == REG_PC);
          end
        end
        WB_LOAD: begin
          if (mem_rvalid) begin
            if (!list_empty) begin
              wb      <= 1'b1;
              wb_addr <= beat_addr;
              wb_data <= mem_rdata;
              pc_wr   <= (beat_addr == REG_PC);
              list    <= list_rest;
              if (list_rest == '0) begin
                ld_done <= 1'b1;
                state   <= WB_IDLE;
              end
            end
          end else if (alu_valid) begin
            wb      <= 1'b1;
            wb_addr <= alu_addr;
            wb_data <= alu_data;
            pc_wr   <= (alu_addr == REG_PC);
          end
        end
        default: state <= WB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_wb_seq.sv
// tb/tb_core_wb_seq.sv - directed table-driven bench for core_wb_seq
module tb_core_wb_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic        alu_ready;
  logic [3:0]  alu_addr;
  logic [31:0] alu_data;
  logic        ld_start;
  logic        ld_ready;
  logic [15:0] ld_reglist;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        ld_done;
  logic        ld_err;
  logic        wb;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        pc_wr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  core_wb_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_addr   (alu_addr),
    .alu_data   (alu_data),
    .ld_start   (ld_start),
    .ld_ready   (ld_ready),
    .ld_reglist (ld_reglist),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .ld_done    (ld_done),
    .ld_err     (ld_err),
    .wb         (wb),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .pc_wr      (pc_wr)
  );

  typedef struct {
    logic        av;
    logic [3:0]  aa;
    logic [31:0] ad;
    logic        ls;
    logic [15:0] ll;
    logic        mv;
    logic [31:0] md;
    logic        e_ard;
    logic        e_lrd;
    logic        e_wb;
    logic [3:0]  e_wa;
    logic [31:0] e_wd;
    logic        e_pc;
    logic        e_done;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic av, logic [3:0] aa, logic [31:0] ad,
                              logic ls, logic [15:0] ll, logic mv, logic [31:0] md,
                              logic e_ard, logic e_lrd, logic e_wb, logic [3:0] e_wa,
                              logic [31:0] e_wd, logic e_pc, logic e_done, logic e_err);
    vec_t v;
    v.av = av; v.aa = aa; v.ad = ad; v.ls = ls; v.ll = ll; v.mv = mv; v.md = md;
    v.e_ard = e_ard; v.e_lrd = e_lrd; v.e_wb = e_wb; v.e_wa = e_wa; v.e_wd = e_wd;
    v.e_pc = e_pc; v.e_done = e_done; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d actual=0x%08h expected=0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [3:0] aa, input logic [31:0] ad,
                       input logic ls, input logic [15:0] ll, input logic mv, input logic [31:0] md);
    alu_valid  = av;
    alu_addr   = aa;
    alu_data   = ad;
    ld_start   = ls;
    ld_reglist = ll;
    mv         = mv;
    mem_rvalid = mv;
    mem_rdata  = md;
  endtask

  // Drive at negedge, check combinational ready outputs, clock, check registered outputs.
  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    drive(v.av, v.aa, v.ad, v.ls, v.ll, v.mv, v.md);
    #1;
    chk("alu_ready", idx, 32'(alu_ready), 32'(v.e_ard));
    chk("ld_ready",  idx, 32'(ld_ready),  32'(v.e_lrd));
    @(posedge clk);
    #1;
    chk("wb",      idx, 32'(wb),      32'(v.e_wb));
    chk("pc_wr",   idx, 32'(pc_wr),   32'(v.e_pc));
    chk("ld_done", idx, 32'(ld_done), 32'(v.e_done));
    chk("ld_err",  idx, 32'(ld_err),  32'(v.e_err));
    if (v.e_wb) begin
      chk("wb_addr", idx, 32'(wb_addr), 32'(v.e_wa));
      chk("wb_data", idx, wb_data, v.e_wd);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 4'd0, 32'd0, 1'b0, 16'd0, 1'b0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb",       -1, 32'(wb),       32'd0);
    chk("rst_wb_addr",  -1, 32'(wb_addr),  32'd0);
    chk("rst_wb_data",  -1, wb_data,       32'd0);
    chk("rst_pc_wr",    -1, 32'(pc_wr),    32'd0);
    chk("rst_ld_done",  -1, 32'(ld_done),  32'd0);
    chk("rst_ld_err",   -1, 32'(ld_err),   32'd0);
    chk("rst_ld_ready", -1, 32'(ld_ready), 32'd1);
    chk("rst_alu_ready",-1, 32'(alu_ready),32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    //                 av   aa     ad            ls   ll        mv   md            ard  lrd  wb   wa     wd            pc   done err
    // ALU only
    vecs.push_back(mk(1'b1, 4'd3,  32'hDEADBEEF, 1'b0, 16'h0000, 1'b0, 32'h0,       1'b1,1'b1,1'b1,4'd3, 32'hDEADBEEF,1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b0, 4'd0,  32'h0,        1'b0, 16'h0000, 1'b0, 32'h0,       1'b1,1'b1,1'b0,4'd0, 32'h0,       1'b0,1'b0,1'b0));
    // LDM 0x8005: r0, r2, r15
    vecs.push_back(mk(1'b0, 4'd0,  32'h0,        1'b1, 16'h8005, 1'b0, 32'h0,       1'b1,1'b1,1'b0,4'd0, 32'h0,       1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b0, 4'd0,  32'h0,        1'b0, 16'h0000, 1'b1, 32'h11,      1'b0,1'b0,1'b1,4'd0, 32'h11,      1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b0, 4'd0,  32'h0,        1'b0, 16'h0000, 1'b1, 32'h22,      1'b0,1'b0,1'b1,4'd2, 32'h22,      1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b0, 4'd0,  32'h0,        1'b0, 16'h0000, 1'b1, 32'h33,      1'b0,1'b0,1'b1,4'd15,32'h33,      1'b1,1'b1,1'b0));
    vecs.push_back(mk(1'b0, 4'd0,  32'h0,        1'b0, 16'h0000, 1'b0, 32'h0,       1'b1,1'b1,1'b0,4'd0, 32'h0,       1'b0,1'b0,1'b0));
    // Conflict in LOAD: mem first, ALU held and written next cycle
    vecs.push_back(mk(1'b0, 4'd0,  32'h0,        1'b1, 16'h0006, 1'b0, 32'h0,       1'b1,1'b1,1'b0,4'd0, 32'h0,       1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b1, 4'd7,  32'hA5A5A5A5, 1'b0, 16'h0000, 1'b1, 32'h44,      1'b0,1'b0,1'b1,4'd1, 32'h44,      1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b1, 4'd7,  32'hA5A5A5A5, 1'b0, 16'h0000, 1'b0, 32'h0,       1'b1,1'b0,1'b1,4'd7, 32'hA5A5A5A5,1'b0,1'b0,1'b0));
    // ld_start while in LOAD is ignored; remaining list stays {r2}
    vecs.push_back(mk(1'b0, 4'd0,  32'h0,        1'b1, 16'hFFFF, 1'b0, 32'h0,       1'b1,1'b0,1'b0,4'd0, 32'h0,       1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b0, 4'd0,  32'h0,        1'b0, 16'h0000, 1'b1, 32'h55,      1'b0,1'b0,1'b1,4'd2, 32'h55,      1'b0,1'b1,1'b0));
    // Empty list: immediate ld_done, no write
    vecs.push_back(mk(1'b0, 4'd0,  32'h0,        1'b1, 16'h0000, 1'b0, 32'h0,       1'b1,1'b1,1'b0,4'd0, 32'h0,       1'b0,1'b1,1'b0));
    vecs.push_back(mk(1'b0, 4'd0,  32'h0,        1'b0, 16'h0000, 1'b0, 32'h0,       1'b1,1'b1,1'b0,4'd0, 32'h0,       1'b0,1'b0,1'b0));
    // Stray beat in IDLE, ALU still accepted (r15 -> pc_wr)
    vecs.push_back(mk(1'b1, 4'd15, 32'h12345678, 1'b0, 16'h0000, 1'b1, 32'h66,      1'b1,1'b1,1'b1,4'd15,32'h12345678,1'b1,1'b0,1'b1));
    vecs.push_back(mk(1'b0, 4'd0,  32'h0,        1'b0, 16'h0000, 1'b1, 32'h67,      1'b1,1'b1,1'b0,4'd0, 32'h0,       1'b0,1'b0,1'b1));
    // Beat in the ld_start cycle is stray; data starts the following cycle
    vecs.push_back(mk(1'b0, 4'd0,  32'h0,        1'b1, 16'h0010, 1'b1, 32'h77,      1'b1,1'b1,1'b0,4'd0, 32'h0,       1'b0,1'b0,1'b1));
    vecs.push_back(mk(1'b0, 4'd0,  32'h0,        1'b0, 16'h0000, 1'b1, 32'h88,      1'b0,1'b0,1'b1,4'd4, 32'h88,      1'b0,1'b1,1'b0));
    // Duplicate ALU destinations written in order
    vecs.push_back(mk(1'b1, 4'd5,  32'h1,        1'b0, 16'h0000, 1'b0, 32'h0,       1'b1,1'b1,1'b1,4'd5, 32'h1,       1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b1, 4'd5,  32'h2,        1'b0, 16'h0000, 1'b0, 32'h0,       1'b1,1'b1,1'b1,4'd5, 32'h2,       1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b0, 4'd0,  32'h0,        1'b0, 16'h0000, 1'b0, 32'h0,       1'b1,1'b1,1'b0,4'd0, 32'h0,       1'b0,1'b0,1'b0));

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Reset mid-LDM: one beat of three, then reset abandons the sequence.
    run_vec(mk(1'b0, 4'd0, 32'h0, 1'b1, 16'h0111, 1'b0, 32'h0, 1'b1,1'b1,1'b0,4'd0,32'h0,1'b0,1'b0,1'b0), 100);
    run_vec(mk(1'b0, 4'd0, 32'h0, 1'b0, 16'h0000, 1'b1, 32'hAA, 1'b0,1'b0,1'b1,4'd0,32'hAA,1'b0,1'b0,1'b0), 101);
    @(negedge clk);
    drive(1'b0, 4'd0, 32'd0, 1'b0, 16'd0, 1'b0, 32'd0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_ld_ready", 102, 32'(ld_ready), 32'd1);
    chk("midrst_ld_done",  102, 32'(ld_done),  32'd0);
    chk("midrst_wb",       102, 32'(wb),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(mk(1'b0, 4'd0, 32'h0, 1'b0, 16'h0000, 1'b0, 32'h0,  1'b1,1'b1,1'b0,4'd0,32'h0,1'b0,1'b0,1'b0), 103);
    run_vec(mk(1'b0, 4'd0, 32'h0, 1'b0, 16'h0000, 1'b1, 32'hBB, 1'b1,1'b1,1'b0,4'd0,32'h0,1'b0,1'b0,1'b1), 104);
    run_vec(mk(1'b0, 4'd0, 32'h0, 1'b0, 16'h0000, 1'b0, 32'h0,  1'b1,1'b1,1'b0,4'd0,32'h0,1'b0,1'b0,1'b0), 105);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
